silife_scan: RTL and testbench
==============================

SILIFE_SCAN -- requirements
Module: silife_scan

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 invert  input  1  output polarity select: 0 = active-high drive, 1 = every bit of rows and columns inverted.
REQ-005 cycles  input  16  number of clk cycles each row is held (dwell time).
REQ-006 cells  input  8  cell states of the row addressed by row_select, from an external combinational read; bit j = column j.
REQ-007 row_select  output  3  index of the row currently being scanned, 0..7.
REQ-008 rows  output  8  row drive, one-hot; bit i = row i.
REQ-009 columns  output  8  column drive; bit j = cells[j] of the displayed row.

Function
REQ-010 State SHALL be a 3-bit row index (drives row_select) and a 16-bit dwell counter.
REQ-011 While the counter is below the effective dwell minus 1, it SHALL increment by 1 each cycle, and row_select SHALL hold.
- Effective dwell = max(cycles, 1).
REQ-012 When the counter is at or above the effective dwell minus 1, on that cycle the counter SHALL clear to 0 and row_select SHALL advance by 1.
- Wraps 7 -> 0.
- Each row is therefore selected for exactly max(cycles,1) consecutive cycles.
REQ-013 cycles = 0 SHALL behave identically to cycles = 1.
- row_select advances every cycle.
REQ-014 cycles SHALL be sampled every cycle, with no latching.
- A change mid-dwell applies immediately via the comparison in REQ-011/012.
- If the counter already exceeds the new limit, the row advances on the next edge.
REQ-015 rows and columns SHALL be registered and updated every non-reset cycle:
- rows <= (1 << row_select) XOR {8{invert}}
- columns <= cells XOR {8{invert}}
- Both use row_select and cells as they stand before that edge.
REQ-016 Consequence of REQ-015: rows and columns SHALL lag row_select by exactly one clock.
- Within the lag, rows and columns always describe the same row.
REQ-017 A change on invert SHALL take effect on the next clock edge's rows/columns update, with no other state change.
REQ-018 The scan SHALL free-run continuously.
- No enable, no handshake.
- Frame period = 8 x max(cycles,1) clocks.
REQ-019 The design SHALL contain no combinational path from cells or invert to any output.

Reset
REQ-020 While reset is high at a clock edge, the module SHALL set:
- row_select = 0
- dwell counter = 0
- rows = 8'h00
- columns = 8'h00 (regardless of invert)
REQ-021 Reset asserted mid-dwell or mid-frame SHALL abandon the current row.
- After release, scanning SHALL restart at row 0 with a full dwell.
REQ-022 On the first edge after reset deasserts, the module SHALL:
- load rows/columns from row 0;
- count the first dwell cycle for row 0.

Verification
REQ-023 Scan order and dwell: cycles = 3, reset released -> row_select sequence 0,0,0,1,1,1,...,7,7,7,0; 24-clock frame period.
REQ-024 Data mapping, cycles = 3, invert = 0.
- Stimulus: cells = 0x20 for row 0, 0x24 for row 4, 0x66 for row 6, 0xAA for row 7, 0x00 for all other rows.
- Response, one clock after each selection: rows = 0x01, columns = 0x20 (row 0); rows = 0x10, columns = 0x24 (row 4); rows = 0x80, columns = 0xAA (row 7); rows = 0x02, columns = 0x00 (row 1).
REQ-025 Inversion: same grid with invert = 1.
- Row 6: rows = 0xBF, columns = 0x99.
- Row 0: rows = 0xFE, columns = 0xDF.
- Row select timing is unchanged from REQ-023.
REQ-026 Reset values: assert reset with invert = 1 -> rows = 0x00, columns = 0x00, row_select = 0.
REQ-027 Reset mid-frame: pulse reset while row_select = 5 -> row_select = 0, then 3-cycle dwell per row.
REQ-028 Edge dwell: cycles = 0 and cycles = 1 -> row_select increments every clock.
- Reducing cycles from 10 to 2 while the counter = 6 -> the row advances on the next edge.

Source files
------------

// File: rtl/silife_scan.sv
// silife_scan: row-scan driver for an 8x8 LED matrix.
//
// Each row is held for max(cycles, 1) clocks. The scan then advances to the
// next row and wraps from row 7 to row 0, free-running with no enable. The
// current row index is presented on row_select. The external cell store
// returns that row's contents on cells, combinationally. The row and column
// drives are registered, so they lag row_select by exactly one clock and
// always describe the same row.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   reset      in   1   synchronous, active-high
//   invert     in   1   0 = active-high drive, 1 = rows/columns inverted
//   cycles     in  16   dwell per row in clocks (0 behaves as 1)
//   cells      in   8   cell states of the row addressed by row_select
//   row_select out  3   row currently being scanned
//   rows       out  8   one-hot row drive (registered)
//   columns    out  8   column drive (registered)

module silife_scan (
    input  logic        clk,
    input  logic        reset,
    input  logic        invert,
    input  logic [15:0] cycles,
    input  logic [7:0]  cells,
    output logic [2:0]  row_select,
    output logic [7:0]  rows,
    output logic [7:0]  columns
);

    logic [2:0]  row_q, row_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rows_q, rows_d;
    logic [7:0]  columns_q, columns_d;
    logic [15:0] dwell_limit;

    // cycles is used live every cycle, with no latching. If the limit drops
    // below the current count, the >= compare advances the row on the next edge.
    always_comb begin
        dwell_limit = (cycles == 16'd0) ? 16'd0 : (cycles - 16'd1);
    end

    always_comb begin
        row_d     = row_q;
        cnt_d     = cnt_q;
        rows_d    = (8'h01 << row_q) ^ {8{invert}};
        columns_d = cells ^ {8{invert}};

        if (cnt_q >= dwell_limit) begin
            cnt_d = 16'd0;
            row_d = row_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q     <= 3'd0;
            cnt_q     <= 16'd0;
            rows_q    <= 8'h00;
            columns_q <= 8'h00;
        end else begin
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            rows_q    <= rows_d;
            columns_q <= columns_d;
        end
    end

    assign row_select = row_q;
    assign rows       = rows_q;
    assign columns    = columns_q;

endmodule

// File: tb/tb_silife_scan.sv
module tb_silife_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        invert;
    logic [15:0] cycles;
    logic [7:0]  cells;
    logic [2:0]  row_select;
    logic [7:0]  rows;
    logic [7:0]  columns;

    logic [7:0]  grid [8];

    typedef struct packed {
        logic [2:0] rs;
        logic [7:0] rw;
        logic [7:0] cl;
    } exp_t;

    exp_t sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [2:0] m_row = 3'd0;
    int         m_cnt = 0;
    logic [7:0] m_rows = 8'h00;
    logic [7:0] m_cols = 8'h00;

    silife_scan dut (
        .clk        (clk),
        .reset      (reset),
        .invert     (invert),
        .cycles     (cycles),
        .cells      (cells),
        .row_select (row_select),
        .rows       (rows),
        .columns    (columns)
    );

    always #5 clk = ~clk;

    // External combinational cell store
    always_comb cells = grid[row_select];

    // Advance the model from the inputs as driven, queue the expectation, clock once.
    task automatic tick();
        int eff;
        if (reset) begin
            m_row  = 3'd0;
            m_cnt  = 0;
            m_rows = 8'h00;
            m_cols = 8'h00;
        end else begin
            eff    = (cycles == 16'd0) ? 1 : int'(cycles);
            m_rows = (8'h01 << m_row) ^ {8{invert}};
            m_cols = grid[m_row] ^ {8{invert}};
            if (m_cnt + 1 >= eff) begin
                m_cnt = 0;
                m_row = 3'(m_row + 3'd1);
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        sb.push_back('{rs: m_row, rw: m_rows, cl: m_cols});
        @(posedge clk);
        #1;
    endtask

    task automatic load_grid();
        for (int i = 0; i < 8; i++) grid[i] = 8'h00;
        grid[0] = 8'h20;
        grid[4] = 8'h24;
        grid[6] = 8'h66;
        grid[7] = 8'hAA;
    endtask

    task automatic test_reset();
        exp_t e;
        reset  = 1'b1;
        invert = 1'b1;
        cycles = 16'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if (row_select !== 3'd0 || rows !== 8'h00 || columns !== 8'h00 ||
                row_select !== e.rs || rows !== e.rw || columns !== e.cl) begin
                n_fail++;
                $display("FAIL reset: got rs=%0d rows=%h cols=%h, want rs=0 rows=00 cols=00",
                         row_select, rows, columns);
            end
        end
    endtask

    task automatic test_scan_order();
        exp_t e;
        invert = 1'b0;
        cycles = 16'd3;
        reset  = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if (row_select !== 3'((k / 3) % 8) || row_select !== e.rs ||
                rows !== e.rw || columns !== e.cl) begin
                n_fail++;
                $display("FAIL scan_order k=%0d: got rs=%0d rows=%h cols=%h, want rs=%0d rows=%h cols=%h",
                         k, row_select, rows, columns, (k / 3) % 8, e.rw, e.cl);
            end
        end
    endtask

    task automatic test_data_mapping(input logic inv);
        exp_t       e;
        int         r;
        logic [7:0] want_r;
        logic [7:0] want_c;
        logic       known;
        reset  = 1'b1;
        invert = inv;
        cycles = 16'd3;
        tick();
        void'(sb.pop_front());
        reset = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            e = sb.pop_front();
            r = ((k - 1) / 3) % 8;
            known  = 1'b1;
            want_r = e.rw;
            want_c = e.cl;
            if (!inv) begin
                case (r)
                    0: begin want_r = 8'h01; want_c = 8'h20; end
                    1: begin want_r = 8'h02; want_c = 8'h00; end
                    4: begin want_r = 8'h10; want_c = 8'h24; end
                    7: begin want_r = 8'h80; want_c = 8'hAA; end
                    default: known = 1'b0;
                endcase
            end else begin
                case (r)
                    0: begin want_r = 8'hFE; want_c = 8'hDF; end
                    6: begin want_r = 8'hBF; want_c = 8'h99; end
                    default: known = 1'b0;
                endcase
            end
            n_tests++;
            if (rows !== want_r || columns !== want_c || rows !== e.rw ||
                columns !== e.cl || row_select !== e.rs ||
                row_select !== 3'((k / 3) % 8)) begin
                n_fail++;
                $display("FAIL data_map inv=%0b k=%0d spec_row=%0b: got rs=%0d rows=%h cols=%h, want rs=%0d rows=%h cols=%h",
                         inv, k, known, row_select, rows, columns, e.rs, want_r, want_c);
            end
        end
    endtask

    task automatic test_invert_toggle();
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            invert = k[0];
            tick();
            e = sb.pop_front();
            n_tests++;
            if (rows !== e.rw || columns !== e.cl || row_select !== e.rs) begin
                n_fail++;
                $display("FAIL invert_toggle k=%0d: got rows=%h cols=%h, want rows=%h cols=%h",
                         k, rows, columns, e.rw, e.cl);
            end
        end
        invert = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int   guard;
        cycles = 16'd3;
        invert = 1'b0;
        guard  = 0;
        while (m_row != 3'd5 && guard < 60) begin
            tick();
            e = sb.pop_front();
            guard++;
        end
        n_tests++;
        if (row_select !== 3'd5) begin
            n_fail++;
            $display("FAIL reach_row5: got rs=%0d, want 5", row_select);
        end
        tick();
        void'(sb.pop_front());
        reset = 1'b1;
        tick();
        e = sb.pop_front();
        n_tests++;
        if (row_select !== 3'd0 || rows !== 8'h00 || columns !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid: got rs=%0d rows=%h cols=%h, want rs=0 rows=00 cols=00",
                     row_select, rows, columns);
        end
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if (row_select !== 3'((k / 3) % 8) || row_select !== e.rs ||
                rows !== e.rw || columns !== e.cl) begin
                n_fail++;
                $display("FAIL after_reset k=%0d: got rs=%0d rows=%h, want rs=%0d rows=%h",
                         k, row_select, rows, (k / 3) % 8, e.rw);
            end
        end
    endtask

    task automatic test_edge_dwell(input logic [15:0] cyc);
        exp_t       e;
        logic [2:0] prev;
        cycles = cyc;
        tick();
        void'(sb.pop_front());
        for (int k = 0; k < 10; k++) begin
            prev = row_select;
            tick();
            e = sb.pop_front();
            n_tests++;
            if (row_select !== 3'(prev + 3'd1) || row_select !== e.rs ||
                rows !== e.rw || columns !== e.cl) begin
                n_fail++;
                $display("FAIL edge_dwell cycles=%0d k=%0d: got rs=%0d, want rs=%0d",
                         cyc, k, row_select, 3'(prev + 3'd1));
            end
        end
    endtask

    task automatic test_cycles_change();
        exp_t e;
        reset  = 1'b1;
        cycles = 16'd10;
        tick();
        void'(sb.pop_front());
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if (row_select !== 3'd0 || row_select !== e.rs || rows !== e.rw) begin
                n_fail++;
                $display("FAIL dwell10 k=%0d: got rs=%0d, want 0", k, row_select);
            end
        end
        cycles = 16'd2;
        tick();
        e = sb.pop_front();
        n_tests++;
        if (row_select !== 3'd1 || row_select !== e.rs || rows !== e.rw) begin
            n_fail++;
            $display("FAIL cycles_shrink: got rs=%0d rows=%h, want rs=1 rows=%h",
                     row_select, rows, e.rw);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            e = sb.pop_front();
            n_tests++;
            if (row_select !== e.rs || rows !== e.rw || columns !== e.cl) begin
                n_fail++;
                $display("FAIL dwell2 k=%0d: got rs=%0d, want rs=%0d", k, row_select, e.rs);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        invert = 1'b0;
        cycles = 16'd3;
        load_grid();
        test_reset();
        test_scan_order();
        test_data_mapping(1'b0);
        test_data_mapping(1'b1);
        test_invert_toggle();
        test_reset_mid_frame();
        test_edge_dwell(16'd0);
        test_edge_dwell(16'd1);
        test_cycles_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
